// File: rtl/uart_boot_pkg.sv
// Shared constants and state encoding for the UART boot loader.
package uart_boot_pkg;

  localparam int unsigned ADR_W  = 2;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  // UART controller register map (word addresses on the Wishbone port)
  localparam logic [ADR_W-1:0] REG_CTRL   = 2'd0;
  localparam logic [ADR_W-1:0] REG_STATUS = 2'd1;
  localparam logic [ADR_W-1:0] REG_RXDATA = 2'd2;
  localparam logic [ADR_W-1:0] REG_TXDATA = 2'd3;

  // Status register bit positions
  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_RX_FULL  = 2;
  localparam int unsigned ST_RX_EMPTY = 3;

  // Reply bytes sent back to the host
  localparam logic [BYTE_W-1:0] ACK = 8'h06;
  localparam logic [BYTE_W-1:0] NAK = 8'h15;

  // Byte selects per access type
  localparam logic [SEL_W-1:0] SEL_CTRL = 4'b1101;
  localparam logic [SEL_W-1:0] SEL_TX   = 4'b0001;
  localparam logic [SEL_W-1:0] SEL_RD   = 4'b1111;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CFG      = 4'd1,
    S_RX_POLL  = 4'd2,
    S_RX_READ  = 4'd3,
    S_MEM_WR   = 4'd4,
    S_TX_POLL  = 4'd5,
    S_TX_WRITE = 4'd6,
    S_DONE     = 4'd7,
    S_ERROR    = 4'd8
  } boot_state_e;

endpackage

// File: rtl/uart_wb_master.sv
// Single-outstanding Wishbone master: one access per start pulse, done pulses
// the cycle after ack with the captured read data.
module uart_wb_master
  import uart_boot_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              we_i,
  input  logic [ADR_W-1:0]  adr_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADR_W-1:0]  wb_adr_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i
);

  logic              act_q, act_d;
  logic              we_q, we_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Launch on start when idle; retire on ack, dropping cyc/stb at the next edge
  always_comb begin
    act_d   = act_q;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    if (!act_q) begin
      if (start_i) begin
        act_d = 1'b1;
        we_d  = we_i;
        adr_d = adr_i;
        sel_d = sel_i;
        dat_d = wdata_i;
      end
    end else if (wb_ack_i) begin
      act_d   = 1'b0;
      we_d    = 1'b0;
      done_d  = 1'b1;
      rdata_d = wb_dat_i;
    end
  end

  // Registers with synchronous reset; an in-flight access is abandoned
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      act_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      act_q   <= act_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign wb_cyc_o = act_q;
  assign wb_stb_o = act_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_sel_o = sel_q;
  assign wb_dat_o = dat_q;
  assign done_o   = done_q;
  assign rdata_o  = rdata_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Boot-time image downloader: configures the UART, receives a word-count
// header and payload words, writes them to instruction memory, replies
// ACK/NAK and then releases the core from reset.
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV  = 16'd868,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              boot_en_i,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADR_W-1:0]  wb_adr_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  output logic              mem_req_o,
  output logic [31:0]       mem_adr_o,
  output logic [31:0]       mem_dat_o,
  input  logic              mem_gnt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic              core_rst_no
);

  boot_state_e       state_q, state_d;
  logic              pend_q, pend_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic              hdr_q, hdr_d;
  logic [31:0]       n_q, n_d;
  logic [31:0]       word_cnt_q, word_cnt_d;
  logic [7:0]        reply_q, reply_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       mem_adr_q, mem_adr_d;
  logic [31:0]       mem_dat_q, mem_dat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              core_rst_n_q, core_rst_n_d;

  logic              bus_start_c, bus_we_c, bus_done, accept_c, bus_state_c;
  logic [ADR_W-1:0]  bus_adr_c;
  logic [SEL_W-1:0]  bus_sel_c;
  logic [DATA_W-1:0] bus_wdata_c, bus_rdata;
  logic [31:0]       full_word_c, wc_inc_c;
  logic              unused_rdata_c;

  uart_wb_master u_wb_master (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (bus_start_c),
    .we_i     (bus_we_c),
    .adr_i    (bus_adr_c),
    .sel_i    (bus_sel_c),
    .wdata_i  (bus_wdata_c),
    .done_o   (bus_done),
    .rdata_o  (bus_rdata),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_sel_o (wb_sel_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

  // Only the low byte and the status flags of read data are meaningful
  assign unused_rdata_c = ^bus_rdata[31:8];

  // Next-state, bus sequencing and datapath updates
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    hdr_d        = hdr_q;
    n_d          = n_q;
    word_cnt_d   = word_cnt_q;
    reply_d      = reply_q;
    mem_req_d    = mem_req_q;
    mem_adr_d    = mem_adr_q;
    mem_dat_d    = mem_dat_q;
    error_d      = error_q;
    bus_start_c  = 1'b0;
    bus_we_c     = 1'b0;
    bus_adr_c    = REG_STATUS;
    bus_sel_c    = SEL_RD;
    bus_wdata_c  = '0;
    full_word_c  = {bus_rdata[7:0], word_q[23:0]};
    wc_inc_c     = word_cnt_q + 32'd1;
    bus_state_c  = state_q inside {S_CFG, S_RX_POLL, S_RX_READ, S_TX_POLL, S_TX_WRITE};

    // Issue one access per visit; the result is consumed when done pulses
    if (bus_state_c && !pend_q) begin
      bus_start_c = 1'b1;
      pend_d      = 1'b1;
    end
    accept_c = pend_q & bus_done;
    if (accept_c) pend_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (boot_en_i) begin
          state_d    = S_CFG;
          hdr_d      = 1'b1;
          byte_cnt_d = 2'd0;
          word_cnt_d = '0;
          n_d        = '0;
          word_d     = '0;
        end else begin
          state_d = S_DONE;
        end
      end
      S_CFG: begin
        bus_we_c    = 1'b1;
        bus_adr_c   = REG_CTRL;
        bus_sel_c   = SEL_CTRL;
        bus_wdata_c = {BAUD_DIV, 14'b0, 1'b1, 1'b1};
        if (accept_c) state_d = S_RX_POLL;
      end
      S_RX_POLL: begin
        if (accept_c && !bus_rdata[ST_RX_EMPTY]) state_d = S_RX_READ;
      end
      S_RX_READ: begin
        bus_adr_c = REG_RXDATA;
        if (accept_c) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d[{byte_cnt_q, 3'b000} +: 8] = bus_rdata[7:0];
          state_d = S_RX_POLL;
          if (byte_cnt_q == 2'd3) begin
            if (hdr_q) begin
              if (full_word_c == 32'd0) begin
                state_d = S_TX_POLL;
                reply_d = ACK;
              end else if (full_word_c > 32'(MAX_WORDS)) begin
                state_d = S_TX_POLL;
                reply_d = NAK;
                error_d = 1'b1;
              end else begin
                n_d        = full_word_c;
                hdr_d      = 1'b0;
                word_cnt_d = '0;
              end
            end else begin
              state_d   = S_MEM_WR;
              mem_req_d = 1'b1;
              mem_adr_d = BASE_ADDR + {word_cnt_q[29:0], 2'b00};
              mem_dat_d = full_word_c;
            end
          end
        end
      end
      S_MEM_WR: begin
        if (mem_gnt_i) begin
          mem_req_d  = 1'b0;
          word_cnt_d = wc_inc_c;
          if (wc_inc_c == n_q) begin
            state_d = S_TX_POLL;
            reply_d = ACK;
          end else begin
            state_d = S_RX_POLL;
          end
        end
      end
      S_TX_POLL: begin
        if (accept_c && !bus_rdata[ST_TX_FULL]) state_d = S_TX_WRITE;
      end
      S_TX_WRITE: begin
        bus_we_c    = 1'b1;
        bus_adr_c   = REG_TXDATA;
        bus_sel_c   = SEL_TX;
        bus_wdata_c = {24'b0, reply_q};
        if (accept_c) state_d = error_q ? S_ERROR : S_DONE;
      end
      default: ;
    endcase

    busy_d       = state_d inside {S_CFG, S_RX_POLL, S_RX_READ, S_MEM_WR, S_TX_POLL, S_TX_WRITE};
    done_d       = (state_d == S_DONE);
    core_rst_n_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      pend_q       <= 1'b0;
      byte_cnt_q   <= 2'd0;
      word_q       <= '0;
      hdr_q        <= 1'b0;
      n_q          <= '0;
      word_cnt_q   <= '0;
      reply_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_adr_q    <= '0;
      mem_dat_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      hdr_q        <= hdr_d;
      n_q          <= n_d;
      word_cnt_q   <= word_cnt_d;
      reply_q      <= reply_d;
      mem_req_q    <= mem_req_d;
      mem_adr_q    <= mem_adr_d;
      mem_dat_q    <= mem_dat_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_adr_o   = mem_adr_q;
  assign mem_dat_o   = mem_dat_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign core_rst_no = core_rst_n_q;

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Wishbone master that sequences the UART register-mapped controller to download a program image at boot.
- Configures baud/enables, polls status, pops RX bytes, assembles little-endian words and writes them to instruction memory.
- Replies with a one-byte ACK/NAK, then releases the core from reset.
- Sits between the UART controller's Wishbone slave port, the memory write port and the core reset.

Parameters:
- BAUD_DIV, 16'd868, value written to ctrl[31:16].
- BASE_ADDR, 32'h0000_0000, byte address of the first image word.
- MAX_WORDS, 4096, largest accepted word count; must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- boot_en_i  in  1  sampled in IDLE; 1 = download, 0 = skip straight to DONE
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  2  0=ctrl, 1=status, 2=rx data, 3=tx data
- wb_sel_o  out  4  byte selects
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data, valid in the ack cycle
- wb_ack_i  in  1  slave acknowledge
- mem_req_o  out  1  memory write request; held until grant
- mem_adr_o  out  32  byte address
- mem_dat_o  out  32  write data
- mem_gnt_i  in  1  write accepted this cycle
- busy_o  out  1  download in progress
- done_o  out  1  image loaded or skipped (sticky)
- error_o  out  1  header rejected (sticky)
- core_rst_no  out  1  core reset, active low; 0 until DONE

Behaviour:
- Synchronous reset (rst_ni=0 at a posedge):
  - All wb_* outputs, mem_req_o, busy_o, done_o, error_o and core_rst_no are 0; mem_adr_o and mem_dat_o are 0.
  - FSM returns to IDLE from any state, including mid-transaction; the slave is not waited on.
- Wishbone transaction engine:
  - One outstanding access; cyc=stb=1 from issue until ack.
  - On the ack cycle: capture wb_dat_i; drop cyc/stb on the next edge.
  - At least one idle cycle between accesses, because the slave toggles ack when stb is held.
  - Writes to ctrl use sel=4'b1101; writes to tx data use sel=4'b0001 with data in [7:0]; reads use sel=4'b1111.
- FSM states:
  - IDLE: if boot_en_i=0, go to DONE; else go to CFG with busy_o=1.
  - CFG: write ctrl = {BAUD_DIV, 14'b0, rx_en=1, tx_en=1}.
  - RX_POLL: read status; if status[3] (rx_empty) = 1, re-poll; else go to RX_READ.
  - RX_READ: read rx data and place byte [7:0] at position byte_cnt, byte k into bits [8k+7:8k]. byte_cnt wraps 3->0; on wrap the word is complete.
  - On a complete word:
    - Header phase: the word is N.
      - N=0: go to TX_POLL with reply 0x06.
      - N>MAX_WORDS: go to TX_POLL with reply 0x15 and flag the error.
      - Otherwise: payload phase, word_cnt=0.
    - Payload phase: go to MEM_WR.
  - MEM_WR:
    - Drive mem_adr_o = BASE_ADDR + 4*word_cnt and hold mem_req_o until mem_gnt_i.
    - Grant in the same cycle as the request completes it; mem_req_o is 0 the next cycle.
    - Then increment word_cnt. If word_cnt == N, go to TX_POLL with 0x06; else return to RX_POLL.
  - TX_POLL: read status; if status[0] (tx_full) = 1, re-poll; else go to TX_WRITE.
  - TX_WRITE: write the reply byte to address 3, then go to DONE or ERROR.
  - DONE: done_o=1, core_rst_no=1, busy_o=0; terminal until reset.
  - ERROR: error_o=1, core_rst_no stays 0, busy_o=0; terminal until reset.
- Arithmetic: word_cnt and N compare at 32 bits; address addition wraps modulo 2^32.
- No RX timeout; an idle line keeps the block in RX_POLL indefinitely.
- boot_en_i is ignored outside IDLE.

Decomposition:
- uart_boot_pkg holds:
  - register address constants (CTRL, STATUS, RXDATA, TXDATA);
  - status bit indices (TX_FULL=0, TX_EMPTY=1, RX_FULL=2, RX_EMPTY=3);
  - reply byte constants ACK=8'h06 and NAK=8'h15;
  - the top FSM state enum.
- One sub-module: uart_wb_master, the single-transaction engine. Its interface is start/we/adr/sel/wdata in, done/rdata out, plus the wb_* ports.

Test Plan:
- boot_en_i=0 after reset -> no wb_cyc_o ever; done_o=1 and core_rst_no=1 within 2 cycles.
- Header 01 00 00 00, payload 78 56 34 12 -> a single mem write: adr 0x0, dat 0x12345678. Then a tx write of 0x06 with sel 0001, done_o=1.
- Header N=3 with a slave-model mem_gnt_i delayed 5 cycles -> three writes at 0x0/0x4/0x8; mem_req_o held through the stall; no duplicated or dropped word.
- Header N=MAX_WORDS+1 -> no mem_req_o; tx byte 0x15; error_o=1; core_rst_no=0.
- Hold status tx_full=1 for 20 polls, then clear -> exactly one tx write occurs after the clear.
- Bus check across all of the above: stb never stays high the cycle after ack, and there is at least one idle cycle between accesses.
- Assert rst_ni=0 mid-payload, then rerun -> all outputs return to reset values and the second download completes correctly.
